// File: rtl/spi_mem_pkg.sv
// Shared types and frame constants for the spi_mem bus-side arbiter/controller.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPC   = 3'd1,
        SHIFT = 3'd2,
        RDATA = 3'd3,
        WAIT  = 3'd4
    } ctrl_state_t;

    localparam logic       OP_WRITE      = 1'b1;
    localparam logic       OP_READ       = 1'b0;
    localparam logic [4:0] WR_FRAME_BITS = 5'd16;
    localparam logic [4:0] RD_FRAME_BITS = 5'd8;
    localparam int         MEM_DEPTH     = 32;

    // Serial frame layout: address byte in bits 0..7, data byte in bits 8..15.
    function automatic logic [15:0] build_frame(input logic [7:0] addr8, input logic [7:0] data8);
        return {data8, addr8};
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter: the pointer port wins ties and the pointer
// moves to the losing side whenever a grant is taken.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // One-hot grant from the current requests and pointer.
    always_comb begin
        o_gnt = 2'b00;
        case (r_ptr)
            1'b0: begin
                if (i_req[0]) begin
                    o_gnt = 2'b01;
                end else if (i_req[1]) begin
                    o_gnt = 2'b10;
                end else begin
                    o_gnt = 2'b00;
                end
            end
            1'b1: begin
                if (i_req[1]) begin
                    o_gnt = 2'b10;
                end else if (i_req[0]) begin
                    o_gnt = 2'b01;
                end else begin
                    o_gnt = 2'b00;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (|o_gnt)) begin
            r_ptr <= ~o_gnt[1];
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/spi_mem_arb_ctrl.sv
// Shares one spi_mem between two requesters: round-robin grant, one whole
// serial transaction per grant, op_done watchdog turning silence into err.
module spi_mem_arb_ctrl
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W  = $clog2(MEM_DEPTH),
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [2*ADDR_W-1:0]   i_addr,
    input  logic [2*DATA_W-1:0]   i_wdata,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_done,
    output logic [1:0]            o_err,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_spi_cs,
    output logic                  o_spi_miso,
    input  logic                  i_spi_mosi,
    input  logic                  i_spi_ready,
    input  logic                  i_spi_op_done
);

    localparam int             TCW     = $clog2(TIMEOUT);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

    ctrl_state_t       r_state, w_state_nxt;
    logic [1:0]        r_gnt, w_gnt_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_cs, w_cs_nxt, r_miso, w_miso_nxt, r_op, w_op_nxt;
    logic [15:0]       r_frame, w_frame_nxt;
    logic [4:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_rx, w_rx_nxt;
    logic [TCW-1:0]    r_tcnt, w_tcnt_nxt;

    logic [1:0]        w_arb_gnt;
    logic              w_adv, w_sel, w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [7:0]        w_wdata_sel;
    logic [4:0]        w_frame_len;

    spi_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_advance (w_adv),
        .o_gnt     (w_arb_gnt)
    );

    assign w_sel       = w_arb_gnt[1];
    assign w_we_sel    = w_sel ? i_we[1] : i_we[0];
    assign w_addr_sel  = w_sel ? i_addr[2*ADDR_W-1:ADDR_W] : i_addr[ADDR_W-1:0];
    assign w_wdata_sel = w_sel ? i_wdata[2*DATA_W-1:DATA_W] : i_wdata[DATA_W-1:0];
    assign w_frame_len = (r_op == OP_WRITE) ? WR_FRAME_BITS : RD_FRAME_BITS;

    // Sequencer next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = 2'b00;
        w_err_nxt   = 2'b00;
        w_rdata_nxt = r_rdata;
        w_cs_nxt    = r_cs;
        w_miso_nxt  = r_miso;
        w_op_nxt    = r_op;
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;
        w_rx_nxt    = r_rx;
        w_tcnt_nxt  = r_tcnt;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_adv       = 1'b1;
                    w_gnt_nxt   = w_arb_gnt;
                    w_op_nxt    = w_we_sel;
                    w_frame_nxt = build_frame(8'(w_addr_sel), w_wdata_sel);
                    w_cs_nxt    = 1'b0;
                    w_miso_nxt  = w_we_sel;
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = OPC;
                end else begin
                    w_adv = 1'b0;
                end
            end
            OPC: begin
                // Opcode stays on the line for two cycles before bit 0.
                if (r_cnt == 5'd1) begin
                    w_miso_nxt  = r_frame[0];
                    w_state_nxt = SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            SHIFT: begin
                if (r_cnt == w_frame_len) begin
                    w_cs_nxt    = 1'b1;
                    w_miso_nxt  = 1'b0;
                    w_cnt_nxt   = 5'd0;
                    w_tcnt_nxt  = {TCW{1'b0}};
                    w_state_nxt = (r_op == OP_READ) ? RDATA : WAIT;
                end else begin
                    w_miso_nxt = r_frame[r_cnt[3:0]];
                    w_cnt_nxt  = r_cnt + 5'd1;
                end
            end
            RDATA: begin
                if (i_spi_ready) begin
                    w_rx_nxt    = {i_spi_mosi, r_rx[7:1]};
                    w_cnt_nxt   = r_cnt + 5'd1;
                    w_state_nxt = (r_cnt == 5'd7) ? WAIT : RDATA;
                end else begin
                    w_rx_nxt = r_rx;
                end
                // The watchdog also covers a memory that never raises ready.
                if (r_tcnt == TO_LAST) begin
                    w_done_nxt  = r_gnt;
                    w_err_nxt   = r_gnt;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
            end
            WAIT: begin
                if (i_spi_op_done) begin
                    w_done_nxt  = r_gnt;
                    w_rdata_nxt = (r_op == OP_READ) ? r_rx : r_rdata;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = IDLE;
                end else if (r_tcnt == TO_LAST) begin
                    w_done_nxt  = r_gnt;
                    w_err_nxt   = r_gnt;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 2'b00;
                w_cs_nxt    = 1'b1;
                w_miso_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_rdata <= {DATA_W{1'b0}};
            r_cs    <= 1'b1;
            r_miso  <= 1'b0;
            r_op    <= 1'b0;
            r_frame <= 16'h0000;
            r_cnt   <= 5'd0;
            r_rx    <= 8'h00;
            r_tcnt  <= {TCW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_cs    <= w_cs_nxt;
            r_miso  <= w_miso_nxt;
            r_op    <= w_op_nxt;
            r_frame <= w_frame_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rx    <= w_rx_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;
    assign o_spi_cs   = r_cs;
    assign o_spi_miso = r_miso;

endmodule
